// File: rtl/fazyrv_ifetch.sv
// fazyrv_ifetch: PC-strobed Wishbone-classic instruction fetch with valid/ready hold and flush.
// Define FAZYRV_IFETCH_TIMEOUT_EN to add the TIMEOUT_CYC bus-ack timeout and fetch_err_o pulse.
module fazyrv_ifetch #(
  parameter logic [31:0] RESET_INSTR = 32'h0000_0013,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk_i,
  input  logic        rst_in,
  input  logic [31:0] pc_i,
  input  logic        fetch_i,
  input  logic        flush_i,
  output logic        ibus_cyc_o,
  output logic [31:0] ibus_adr_o,
  input  logic        ibus_ack_i,
  input  logic [31:0] ibus_rdat_i,
  output logic [31:0] instr_o,
  output logic        instr_vld_o,
  input  logic        instr_rdy_i,
  output logic        busy_o,
  output logic        fetch_err_o
);
  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;
  state_t state_q, state_d;
  logic cyc_q, cyc_d, vld_q, vld_d, disc_q, disc_d, err_q, err_d, launch, tout;
  logic [31:0] adr_q, adr_d, instr_q, instr_d;
  logic unused;
  assign unused = ^{pc_i[1:0], TIMEOUT_CYC};
`ifdef FAZYRV_IFETCH_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  assign tout = state_q == REQ && !ibus_ack_i && cnt_q == 16'(TIMEOUT_CYC - 1);
  // counter is zero outside REQ and counts ack-less cycles while REQ persists
  assign cnt_d = (state_q == REQ && state_d == REQ) ? cnt_q + 16'd1 : 16'd0;
  always_ff @(posedge clk_i or negedge rst_in)
    if (!rst_in) cnt_q <= 16'd0;
    else cnt_q <= cnt_d;
`else
  assign tout = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    cyc_d = cyc_q;
    adr_d = adr_q;
    instr_d = instr_q;
    vld_d = vld_q;
    disc_d = disc_q;
    err_d = 1'b0;
    launch = 1'b0;
    case (state_q)
      IDLE: launch = fetch_i && !flush_i;
      REQ:
        if (ibus_ack_i) begin
          cyc_d = 1'b0;
          disc_d = 1'b0;
          state_d = (disc_q || flush_i) ? IDLE : HOLD;
          vld_d = !(disc_q || flush_i);
          instr_d = (disc_q || flush_i) ? instr_q : ibus_rdat_i;
        end else if (tout) begin
          cyc_d = 1'b0;
          err_d = 1'b1;
          disc_d = 1'b0;
          state_d = IDLE;
        end else if (flush_i) disc_d = 1'b1;
      HOLD:
        if (flush_i) begin
          vld_d = 1'b0;
          instr_d = RESET_INSTR;
          state_d = IDLE;
        end else if (instr_rdy_i) begin
          vld_d = 1'b0;
          state_d = IDLE;
          launch = fetch_i;
        end
      default: state_d = IDLE;
    endcase
    if (launch) begin
      state_d = REQ;
      cyc_d = 1'b1;
      adr_d = {pc_i[31:2], 2'b00};
    end
  end
  always_ff @(posedge clk_i or negedge rst_in)
    if (!rst_in) begin
      state_q <= IDLE;
      cyc_q <= 1'b0;
      adr_q <= 32'd0;
      instr_q <= RESET_INSTR;
      vld_q <= 1'b0;
      disc_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q <= cyc_d;
      adr_q <= adr_d;
      instr_q <= instr_d;
      vld_q <= vld_d;
      disc_q <= disc_d;
      err_q <= err_d;
    end
  assign ibus_cyc_o = cyc_q;
  assign ibus_adr_o = adr_q;
  assign instr_o = instr_q;
  assign instr_vld_o = vld_q;
  assign busy_o = state_q != IDLE;
  assign fetch_err_o = err_q;
endmodule

// File: tb/tb_fazyrv_ifetch.sv
// tb_fazyrv_ifetch: directed vector table, hand-written corner sequences and a randomized run
// against a flag-based reference model; honours FAZYRV_IFETCH_TIMEOUT_EN with TIMEOUT_CYC=4.
module tb_fazyrv_ifetch;
  localparam logic [31:0] RI = 32'h0000_0013;
  localparam int TO = 4;
  logic clk_i = 1'b0, rst_in = 1'b0;
  logic [31:0] pc_i = '0, ibus_rdat_i = '0;
  logic fetch_i = 1'b0, flush_i = 1'b0, ibus_ack_i = 1'b0, instr_rdy_i = 1'b0;
  logic ibus_cyc_o, instr_vld_o, busy_o, fetch_err_o;
  logic [31:0] ibus_adr_o, instr_o;
  int checks = 0, errors = 0;

  fazyrv_ifetch #(.RESET_INSTR(RI), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk_i), .rst_in(rst_in), .pc_i(pc_i), .fetch_i(fetch_i), .flush_i(flush_i),
    .ibus_cyc_o(ibus_cyc_o), .ibus_adr_o(ibus_adr_o), .ibus_ack_i(ibus_ack_i),
    .ibus_rdat_i(ibus_rdat_i), .instr_o(instr_o), .instr_vld_o(instr_vld_o),
    .instr_rdy_i(instr_rdy_i), .busy_o(busy_o), .fetch_err_o(fetch_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic f, fl, a, r;
    logic [31:0] pc, rd;
    logic cyc;
    logic [31:0] adr, instr;
    logic vld, busy;
  } vec_t;

  vec_t tbl[25];

  function automatic vec_t v(logic f, logic fl, logic a, logic r, logic [31:0] pc, logic [31:0] rd,
                             logic cyc, logic [31:0] adr, logic [31:0] instr, logic vld, logic busy);
    return '{f: f, fl: fl, a: a, r: r, pc: pc, rd: rd, cyc: cyc, adr: adr, instr: instr, vld: vld, busy: busy};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic f, input logic fl, input logic a, input logic r,
                       input logic [31:0] pc, input logic [31:0] rd);
    fetch_i = f; flush_i = fl; ibus_ack_i = a; instr_rdy_i = r; pc_i = pc; ibus_rdat_i = rd;
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_all(input string tag, input logic cyc, input logic [31:0] adr,
                           input logic [31:0] instr, input logic vld, input logic busy, input logic err);
    check({tag, " cyc"}, 32'(ibus_cyc_o), 32'(cyc));
    check({tag, " adr"}, ibus_adr_o, adr);
    check({tag, " instr"}, instr_o, instr);
    check({tag, " vld"}, 32'(instr_vld_o), 32'(vld));
    check({tag, " busy"}, 32'(busy_o), 32'(busy));
    check({tag, " err"}, 32'(fetch_err_o), 32'(err));
  endtask

  // reference model: an open bus cycle, a pending discard, and a held instruction
  logic m_bus, m_drop, m_have, m_err;
  logic [31:0] m_adr, m_instr;
  int m_wait;

  task automatic model_reset;
    m_bus = 0; m_drop = 0; m_have = 0; m_err = 0; m_adr = 0; m_instr = RI; m_wait = 0;
  endtask

  task automatic model_step(input logic f, input logic fl, input logic a, input logic r,
                            input logic [31:0] pc, input logic [31:0] rd);
    logic start;
    start = 0;
    m_err = 0;
    if (m_bus) begin
      if (a) begin
        m_bus = 0;
        if (!m_drop && !fl) begin m_instr = rd; m_have = 1; end
        m_drop = 0;
      end
`ifdef FAZYRV_IFETCH_TIMEOUT_EN
      else if (m_wait + 1 == TO) begin m_bus = 0; m_drop = 0; m_err = 1; end
`endif
      else begin
        m_wait++;
        if (fl) m_drop = 1;
      end
    end else if (m_have) begin
      if (fl) begin m_have = 0; m_instr = RI; end
      else if (r) begin m_have = 0; start = f; end
    end else start = f && !fl;
    if (start) begin m_bus = 1; m_adr = pc & ~32'd3; m_wait = 0; end
  endtask

  initial begin
    tbl[0]  = v(1,0,0,0, 32'h100, 0,            1, 32'h100, RI,           0, 1);
    tbl[1]  = v(0,0,1,1, 0, 32'h0051_0093,     0, 32'h100, 32'h0051_0093, 1, 1);
    tbl[2]  = v(0,0,0,1, 0, 0,                 0, 32'h100, 32'h0051_0093, 0, 0);
    tbl[3]  = v(1,0,0,0, 32'h100, 0,           1, 32'h100, 32'h0051_0093, 0, 1);
    tbl[4]  = v(0,0,1,0, 0, 32'h00A0_0113,     0, 32'h100, 32'h00A0_0113, 1, 1);
    for (int i = 5; i < 10; i++)
      tbl[i] = v(1,0,1,0, 32'h500, 32'hFFFF_FFFF, 0, 32'h100, 32'h00A0_0113, 1, 1);
    tbl[10] = v(1,0,0,1, 32'h104, 0,           1, 32'h104, 32'h00A0_0113, 0, 1);
    tbl[11] = v(0,0,1,1, 0, 32'h0000_0513,     0, 32'h104, 32'h0000_0513, 1, 1);
    tbl[12] = v(1,1,0,1, 32'h400, 0,           0, 32'h104, RI,           0, 0);
    tbl[13] = v(1,0,0,0, 32'h200, 0,           1, 32'h200, RI,           0, 1);
    tbl[14] = v(0,1,0,0, 0, 0,                 1, 32'h200, RI,           0, 1);
    tbl[15] = v(0,0,0,0, 0, 0,                 1, 32'h200, RI,           0, 1);
    tbl[16] = v(0,0,1,1, 0, 32'hDEAD_BEEF,     0, 32'h200, RI,           0, 0);
    tbl[17] = v(0,0,0,1, 0, 0,                 0, 32'h200, RI,           0, 0);
    tbl[18] = v(1,0,0,0, 32'h302, 0,           1, 32'h300, RI,           0, 1);
    tbl[19] = v(0,1,1,1, 0, 32'h1234_5678,     0, 32'h300, RI,           0, 0);
    tbl[20] = v(0,0,1,1, 0, 32'hAAAA_AAAA,     0, 32'h300, RI,           0, 0);
    tbl[21] = v(1,0,0,0, 32'h40, 0,            1, 32'h40,  RI,           0, 1);
    tbl[22] = v(1,0,0,0, 32'h80, 0,            1, 32'h40,  RI,           0, 1);
    tbl[23] = v(0,0,1,0, 0, 32'h11,            0, 32'h40,  32'h11,       1, 1);
    tbl[24] = v(0,0,0,1, 0, 0,                 0, 32'h40,  32'h11,       0, 0);

    repeat (2) @(posedge clk_i);
    #1;
    check_all("reset", 0, 0, RI, 0, 0, 0);
    @(negedge clk_i);
    rst_in = 1;

    for (int i = 0; i < 25; i++) begin
      drive(tbl[i].f, tbl[i].fl, tbl[i].a, tbl[i].r, tbl[i].pc, tbl[i].rd);
      tick;
      check_all($sformatf("vec%0d", i), tbl[i].cyc, tbl[i].adr, tbl[i].instr, tbl[i].vld, tbl[i].busy, 0);
    end

    drive(1,0,0,0, 32'h600, 0);
    tick;
    check("areset pre cyc", 32'(ibus_cyc_o), 1);
    drive(0,0,0,0, 0, 0);
    #3 rst_in = 0;
    #1;
    check_all("areset", 0, 0, RI, 0, 0, 0);
    @(negedge clk_i);
    rst_in = 1;

    drive(1,0,0,0, 32'h700, 0);
    tick;
    check_all("to start", 1, 32'h700, RI, 0, 1, 0);
    drive(0,0,0,0, 0, 0);
`ifdef FAZYRV_IFETCH_TIMEOUT_EN
    for (int k = 0; k < TO - 1; k++) begin
      tick;
      check_all($sformatf("to wait%0d", k), 1, 32'h700, RI, 0, 1, 0);
    end
    tick;
    check_all("to fire", 0, 32'h700, RI, 0, 0, 1);
    tick;
    check_all("to after", 0, 32'h700, RI, 0, 0, 0);
    drive(1,0,0,0, 32'h704, 0);
    tick;
    drive(0,0,0,0, 0, 0);
    repeat (TO - 1) tick;
    drive(0,0,1,0, 0, 32'h99);
    tick;
    check_all("to ackwin", 0, 32'h704, 32'h99, 1, 1, 0);
`else
    for (int k = 0; k < 20; k++) begin
      tick;
      check_all($sformatf("nowait%0d", k), 1, 32'h700, RI, 0, 1, 0);
    end
    drive(0,0,1,0, 0, 32'h99);
    tick;
    check_all("late ack", 0, 32'h700, 32'h99, 1, 1, 0);
`endif

    drive(0,0,0,0, 0, 0);
    @(negedge clk_i);
    rst_in = 0;
    @(negedge clk_i);
    rst_in = 1;
    model_reset();
    for (int n = 0; n < 600; n++) begin
      logic f, fl, a, r;
      logic [31:0] pc, rd;
      f = $urandom_range(1, 0) == 1;
      fl = $urandom_range(9, 0) == 0;
      a = $urandom_range(9, 0) < 4;
      r = $urandom_range(1, 0) == 1;
      pc = $urandom;
      rd = $urandom;
      drive(f, fl, a, r, pc, rd);
      model_step(f, fl, a, r, pc, rd);
      tick;
      check_all($sformatf("rnd%0d", n), m_bus, m_adr, m_instr, m_have, m_bus || m_have, m_err);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
